// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART: parametrised RX/TX FIFOs, programmable baud divisor,
// 16x oversampled receiver, optional parity, sticky W1C error flags and irq.
module uart_mmio_fifo #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter logic [15:0] DIV_RESET  = 16'd27
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Rx,
   input  logic [15:0] address,
   input  logic [31:0] w_data,
   input  logic        we,
   input  logic        re,
   output logic [31:0] r_data,
   output logic        Tx,
   output logic        irq
);
   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

   logic [19:0]   ctrl_q;
   logic [15:0]   tick_cnt_q;
   logic [7:0]    rx_mem [FIFO_DEPTH];
   logic [7:0]    tx_mem [FIFO_DEPTH];
   logic [PW-1:0] rx_wp_q, rx_rp_q, tx_wp_q, tx_rp_q;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
   logic          ovr_q, ferr_q, perr_q, irq_q, tx_q;
   state_e        tx_state_q, rx_state_q;
   logic [3:0]    tx_sub_q, rx_sub_q;
   logic [2:0]    tx_bit_q, rx_bit_q;
   logic [7:0]    tx_byte_q, rx_byte_q;
   logic [1:0]    rx_sync_q;

   logic [1:0] reg_sel;
   logic       tick, par_en, par_odd, rx_ie, tx_ie;
   logic       rx_ne, rx_full, tx_empty, tx_full, tx_busy, rx_line;
   logic       ctrl_we, stat_we, data_we, rx_pop, rx_push, tx_pop, tx_push;
   logic       tx_bit_end, rx_bit_end, rx_done, set_ovr, set_ferr, set_perr;
   logic       unused_bits;

   assign unused_bits = ^{address[15:4], address[1:0], w_data[31:20]};

   assign reg_sel  = address[3:2];
   assign par_en   = ctrl_q[16];
   assign par_odd  = ctrl_q[17];
   assign rx_ie    = ctrl_q[18];
   assign tx_ie    = ctrl_q[19];
   assign tick     = (tick_cnt_q == ctrl_q[15:0]);

   assign rx_ne    = (rx_cnt_q != '0);
   assign rx_full  = (rx_cnt_q == FULL);
   assign tx_empty = (tx_cnt_q == '0);
   assign tx_full  = (tx_cnt_q == FULL);
   assign tx_busy  = (tx_state_q != IDLE);
   assign rx_line  = rx_sync_q[1];

   assign ctrl_we  = we && (reg_sel == 2'd2);
   assign stat_we  = we && (reg_sel == 2'd1);
   assign data_we  = we && (reg_sel == 2'd0);
   assign rx_pop   = re && (reg_sel == 2'd0) && rx_ne;
   assign tx_push  = data_we && !tx_full;

   assign tx_bit_end = tick && (tx_sub_q == 4'd15);
   assign rx_bit_end = tick && (rx_sub_q == 4'd15);
   // Popping straight out of STOP keeps back-to-back frames free of idle gaps.
   assign tx_pop   = !tx_empty && ((tx_state_q == IDLE) || ((tx_state_q == STOP) && tx_bit_end));
   assign rx_done  = (rx_state_q == STOP) && rx_bit_end;
   assign rx_push  = rx_done && !rx_full;
   assign set_ovr  = rx_done && rx_full;
   assign set_ferr = rx_done && !rx_line;
   assign set_perr = (rx_state_q == PARITY) && rx_bit_end && (rx_line != ((^rx_byte_q) ^ par_odd));

   always_comb begin
      rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
      tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
   end

   always_comb begin
      r_data = '0;
      case (reg_sel)
         2'd0: if (rx_ne) r_data = {24'h0, rx_mem[rx_rp_q]};
         2'd1: r_data = {8'h00, 8'(tx_cnt_q), 8'(rx_cnt_q), tx_busy, perr_q, ferr_q, ovr_q,
                         tx_full, tx_empty, rx_full, rx_ne};
         2'd2: r_data = {12'h000, ctrl_q};
         default: r_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wp_q] <= rx_byte_q;
      if (tx_push) tx_mem[tx_wp_q] <= w_data[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q     <= {4'b0, DIV_RESET};
         tick_cnt_q <= '0;
         rx_wp_q    <= '0;
         rx_rp_q    <= '0;
         tx_wp_q    <= '0;
         tx_rp_q    <= '0;
         rx_cnt_q   <= '0;
         tx_cnt_q   <= '0;
         ovr_q      <= 1'b0;
         ferr_q     <= 1'b0;
         perr_q     <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         if (ctrl_we) ctrl_q <= w_data[19:0];
         tick_cnt_q <= (ctrl_we || tick) ? '0 : tick_cnt_q + 16'd1;
         rx_cnt_q   <= rx_cnt_d;
         tx_cnt_q   <= tx_cnt_d;
         if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
         if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
         if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
         if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
         // Hardware set wins over a same-cycle W1C clear.
         ovr_q  <= (ovr_q  & ~(stat_we & w_data[4])) | set_ovr;
         ferr_q <= (ferr_q & ~(stat_we & w_data[5])) | set_ferr;
         perr_q <= (perr_q & ~(stat_we & w_data[6])) | set_perr;
         irq_q  <= (rx_ie & rx_ne) | (tx_ie & tx_empty) | ovr_q | ferr_q | perr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_q <= IDLE;
         tx_q       <= 1'b1;
         tx_sub_q   <= '0;
         tx_bit_q   <= '0;
         tx_byte_q  <= '0;
      end else if (tx_pop) begin
         tx_state_q <= START;
         tx_q       <= 1'b0;
         tx_sub_q   <= '0;
         tx_byte_q  <= tx_mem[tx_rp_q];
      end else if (tick && (tx_state_q != IDLE)) begin
         tx_sub_q <= tx_sub_q + 4'd1;
         if (tx_sub_q == 4'd15) begin
            case (tx_state_q)
               START: begin
                  tx_state_q <= DATA;
                  tx_bit_q   <= '0;
                  tx_q       <= tx_byte_q[0];
               end
               DATA: begin
                  if (tx_bit_q == 3'd7) begin
                     tx_state_q <= par_en ? PARITY : STOP;
                     tx_q       <= par_en ? ((^tx_byte_q) ^ par_odd) : 1'b1;
                  end else begin
                     tx_bit_q <= tx_bit_q + 3'd1;
                     tx_q     <= tx_byte_q[tx_bit_q + 3'd1];
                  end
               end
               PARITY: begin
                  tx_state_q <= STOP;
                  tx_q       <= 1'b1;
               end
               default: tx_state_q <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_sync_q  <= 2'b11;
         rx_state_q <= IDLE;
         rx_sub_q   <= '0;
         rx_bit_q   <= '0;
         rx_byte_q  <= '0;
      end else begin
         rx_sync_q <= {rx_sync_q[0], Rx};
         if (tick) begin
            case (rx_state_q)
               IDLE: if (!rx_line) begin
                  rx_state_q <= START;
                  rx_sub_q   <= '0;
               end
               START: begin
                  rx_sub_q <= rx_sub_q + 4'd1;
                  // Half-bit check rejects glitches and re-centres sampling mid-bit.
                  if (rx_sub_q == 4'd7) begin
                     rx_sub_q   <= '0;
                     rx_bit_q   <= '0;
                     rx_state_q <= rx_line ? IDLE : DATA;
                  end
               end
               DATA: begin
                  rx_sub_q <= rx_sub_q + 4'd1;
                  if (rx_sub_q == 4'd15) begin
                     rx_byte_q[rx_bit_q] <= rx_line;
                     rx_bit_q <= rx_bit_q + 3'd1;
                     if (rx_bit_q == 3'd7) rx_state_q <= par_en ? PARITY : STOP;
                  end
               end
               PARITY: begin
                  rx_sub_q <= rx_sub_q + 4'd1;
                  if (rx_sub_q == 4'd15) rx_state_q <= STOP;
               end
               default: begin
                  rx_sub_q <= rx_sub_q + 4'd1;
                  if (rx_sub_q == 4'd15) rx_state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign Tx  = tx_q;
   assign irq = irq_q;
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Self-checking bench for uart_mmio_fifo: randomized bus and serial stimulus
// compared against a frame/queue-level reference model.
module tb_uart_mmio_fifo;
   localparam int unsigned DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        Rx = 1'b1;
   logic [15:0] address = '0;
   logic [31:0] w_data = '0;
   logic        we = 1'b0;
   logic        re = 1'b0;
   logic [31:0] r_data;
   logic        Tx;
   logic        irq;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   uart_mmio_fifo #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd27)) dut (
      .clk(clk), .reset(reset), .Rx(Rx), .address(address), .w_data(w_data),
      .we(we), .re(re), .r_data(r_data), .Tx(Tx), .irq(irq)
   );

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address = {12'($urandom), a, 2'($urandom)};
      w_data  = d;
      we      = 1'b1;
      @(posedge clk);
      #1 we = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, input logic pop, output logic [31:0] d);
      @(negedge clk);
      address = {12'($urandom), a, 2'($urandom)};
      re      = pop;
      #1 d = r_data;
      @(posedge clk);
      #1 re = 1'b0;
   endtask

   // Serial frame, LSB first: [0]=start, [8:1]=data, then parity (if any), then stop.
   function automatic logic [10:0] frame_of(input logic [7:0] b, input bit pen, input bit podd);
      logic [10:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = b;
      if (pen) f[9] = (^b) ^ podd;
      return f;
   endfunction

   task automatic send_rx(input logic [7:0] b, input bit pen, input bit podd,
                          input bit bad_par, input bit bad_stop);
      logic [10:0] f;
      int unsigned nb;
      f  = frame_of(b, pen, podd);
      nb = pen ? 11 : 10;
      if (pen && bad_par) f[9] = ~f[9];
      if (bad_stop) f[nb-1] = 1'b0;
      for (int unsigned i = 0; i < nb; i++) begin
         @(negedge clk);
         Rx = f[i];
         repeat (31) @(negedge clk);
      end
      @(negedge clk);
      Rx = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      bus_read(2'd1, 1'b0, d);
      tests++; if (d !== 32'h4) begin fails++; $display("FAIL reset_status: got %h expected %h", d, 32'h4); end
      bus_read(2'd2, 1'b0, d);
      tests++; if (d !== 32'h1B) begin fails++; $display("FAIL reset_ctrl: got %h expected %h", d, 32'h1B); end
      bus_read(2'd0, 1'b1, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_data_empty: got %h expected 0", d); end
      bus_read(2'd3, 1'b0, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL reg3_read: got %h expected 0", d); end
      tests++; if (Tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b expected 1", Tx); end
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b expected 0", irq); end
   endtask

   task automatic test_tx();
      logic [31:0] d;
      logic [7:0]  b;
      logic [10:0] exp, obs;
      bit          pen, podd;
      int unsigned nb;
      for (int unsigned n = 0; n < 4; n++) begin
         b    = (n == 0) ? 8'hA5 : 8'($urandom);
         pen  = (n == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         podd = 1'($urandom_range(0, 1));
         bus_write(2'd2, {14'h0, podd, pen, 16'd1});
         bus_write(2'd0, {24'($urandom), b});
         @(negedge clk);
         tests++; if (Tx !== 1'b1) begin fails++; $display("FAIL tx_idle_on_write: got %b expected 1", Tx); end
         @(negedge clk);
         tests++; if (Tx !== 1'b0) begin fails++; $display("FAIL tx_start_latency: got %b expected 0", Tx); end
         exp = frame_of(b, pen, podd);
         nb  = pen ? 11 : 10;
         obs = '1;
         for (int unsigned k = 0; k < nb; k++) begin
            repeat ((k == 0) ? 16 : 32) @(negedge clk);
            obs[k] = Tx;
         end
         tests++; if (obs !== exp) begin fails++; $display("FAIL tx_frame: got %b expected %b", obs, exp); end
         repeat (20) @(negedge clk);
         bus_read(2'd1, 1'b0, d);
         tests++; if (d !== 32'h4) begin fails++; $display("FAIL tx_done_status: got %h expected %h", d, 32'h4); end
      end
   endtask

   task automatic test_irq();
      bus_write(2'd2, 32'h0008_0001);
      @(negedge clk);
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_lag_rise: got %b expected 0", irq); end
      @(negedge clk);
      tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_tx_empty: got %b expected 1", irq); end
      bus_write(2'd2, 32'h0000_0001);
      @(negedge clk);
      tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_lag_fall: got %b expected 1", irq); end
      @(negedge clk);
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_disabled: got %b expected 0", irq); end
   endtask

   task automatic test_rx();
      logic [31:0] d, exp;
      logic [7:0]  b;
      bit          pen, podd, bad_par, bad_stop;
      for (int unsigned n = 0; n < 7; n++) begin
         b        = (n == 0) ? 8'h3C : 8'($urandom);
         pen      = (n <= 1) ? 1'b1 : 1'($urandom_range(0, 1));
         podd     = (n <= 1) ? 1'b0 : 1'($urandom_range(0, 1));
         bad_par  = pen && ((n == 1) || (n == 4));
         bad_stop = (n == 5) || (n == 6);
         bus_write(2'd2, {14'h0, podd, pen, 16'd1});
         send_rx(b, pen, podd, bad_par, bad_stop);
         repeat (40) @(negedge clk);
         exp = 32'h0000_0105 | (bad_par ? 32'h40 : 32'h0) | (bad_stop ? 32'h20 : 32'h0);
         bus_read(2'd1, 1'b0, d);
         tests++; if (d !== exp) begin fails++; $display("FAIL rx_status: got %h expected %h", d, exp); end
         tests++; if (irq !== (bad_par | bad_stop)) begin fails++; $display("FAIL rx_err_irq: got %b expected %b", irq, bad_par | bad_stop); end
         bus_read(2'd0, 1'b1, d);
         tests++; if (d !== {24'h0, b}) begin fails++; $display("FAIL rx_data: got %h expected %h", d, {24'h0, b}); end
         if (bad_par || bad_stop) bus_write(2'd1, 32'h0000_0070);
         bus_read(2'd1, 1'b0, d);
         tests++; if (d !== 32'h4) begin fails++; $display("FAIL rx_after_pop: got %h expected %h", d, 32'h4); end
         repeat (2) @(negedge clk);
         tests++; if (irq !== 1'b0) begin fails++; $display("FAIL rx_irq_clear: got %b expected 0", irq); end
      end
   endtask

   task automatic test_overrun();
      logic [31:0] d, exp;
      logic [7:0]  b;
      logic [7:0]  mq[$];
      bit          movr;
      int          cnt;
      movr = 1'b0;
      bus_write(2'd2, 32'h0000_0001);
      for (int unsigned i = 0; i < DEPTH + 1; i++) begin
         b = 8'($urandom);
         send_rx(b, 1'b0, 1'b0, 1'b0, 1'b0);
         if (mq.size() < DEPTH) mq.push_back(b);
         else movr = 1'b1;
      end
      repeat (40) @(negedge clk);
      cnt = mq.size();
      exp = 32'h4 | (32'(cnt) << 8) | ((cnt != 0) ? 32'h1 : 32'h0)
            | ((cnt == DEPTH) ? 32'h2 : 32'h0) | (movr ? 32'h10 : 32'h0);
      bus_read(2'd1, 1'b0, d);
      tests++; if (d !== exp) begin fails++; $display("FAIL overrun_status: got %h expected %h", d, exp); end
      while (mq.size() > 0) begin
         b = mq.pop_front();
         bus_read(2'd0, 1'b1, d);
         tests++; if (d !== {24'h0, b}) begin fails++; $display("FAIL overrun_order: got %h expected %h", d, {24'h0, b}); end
      end
      exp = 32'h4 | (movr ? 32'h10 : 32'h0);
      bus_read(2'd1, 1'b0, d);
      tests++; if (d !== exp) begin fails++; $display("FAIL overrun_drained: got %h expected %h", d, exp); end
      bus_write(2'd1, 32'h0000_0010);
      bus_read(2'd1, 1'b0, d);
      tests++; if (d !== 32'h4) begin fails++; $display("FAIL overrun_w1c: got %h expected %h", d, 32'h4); end
   endtask

   task automatic test_tx_full();
      logic [31:0] d;
      logic [7:0]  sent[$];
      logic [7:0]  b;
      logic [8:0]  obs;
      bit          found, low_seen;
      bus_write(2'd2, 32'h0000_FFFF);
      for (int unsigned i = 0; i < DEPTH + 2; i++) begin
         b = 8'($urandom);
         bus_write(2'd0, {24'h0, b});
         // One byte sits in the shift register, DEPTH in the FIFO; the rest are dropped.
         if (i <= DEPTH) sent.push_back(b);
         if (i == DEPTH) begin
            bus_read(2'd1, 1'b0, d);
            tests++; if (d !== 32'h0010_0088) begin fails++; $display("FAIL tx_full_status: got %h expected %h", d, 32'h0010_0088); end
         end
      end
      bus_read(2'd1, 1'b0, d);
      tests++; if (d !== 32'h0010_0088) begin fails++; $display("FAIL tx_full_drop: got %h expected %h", d, 32'h0010_0088); end
      bus_write(2'd2, 32'h0000_0000);
      for (int unsigned n = 0; n < DEPTH + 1; n++) begin
         if (n == 0) begin
            repeat (25) @(negedge clk);
         end else begin
            found = 1'b0;
            for (int i = 0; i < 48 && !found; i++) begin
               @(negedge clk);
               if (Tx === 1'b0) found = 1'b1;
            end
            if (!found) begin
               tests++; fails++;
               $display("FAIL tx_drain_start: no start bit for byte %0d", n);
               break;
            end
            repeat (24) @(negedge clk);
         end
         obs[0] = Tx;
         for (int unsigned j = 1; j < 9; j++) begin
            repeat (16) @(negedge clk);
            obs[j] = Tx;
         end
         tests++;
         if (obs !== {1'b1, sent[n]}) begin
            fails++;
            $display("FAIL tx_drain_byte%0d: got %b expected %b", n, obs, {1'b1, sent[n]});
         end
      end
      low_seen = 1'b0;
      repeat (80) begin
         @(negedge clk);
         if (Tx !== 1'b1) low_seen = 1'b1;
      end
      tests++; if (low_seen !== 1'b0) begin fails++; $display("FAIL tx_extra_frame: got %b expected 0", low_seen); end
      bus_read(2'd1, 1'b0, d);
      tests++; if (d !== 32'h4) begin fails++; $display("FAIL tx_drained_status: got %h expected %h", d, 32'h4); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      logic [7:0]  b;
      bus_write(2'd2, 32'h0001_0001);
      send_rx(8'($urandom), 1'b1, 1'b0, 1'b1, 1'b0);
      repeat (40) @(negedge clk);
      bus_write(2'd0, 32'h00);
      bus_write(2'd0, 32'h55);
      bus_write(2'd0, 32'h77);
      @(negedge clk);
      Rx = 1'b0;
      repeat (90) @(negedge clk);
      tests++; if (Tx !== 1'b0) begin fails++; $display("FAIL tx_low_midframe: got %b expected 0", Tx); end
      reset = 1'b1;
      @(posedge clk);
      #1;
      tests++; if (Tx !== 1'b1) begin fails++; $display("FAIL reset_mid_tx: got %b expected 1", Tx); end
      reset = 1'b0;
      Rx    = 1'b1;
      bus_read(2'd1, 1'b0, d);
      tests++; if (d !== 32'h4) begin fails++; $display("FAIL reset_mid_status: got %h expected %h", d, 32'h4); end
      bus_read(2'd2, 1'b0, d);
      tests++; if (d !== 32'h1B) begin fails++; $display("FAIL reset_mid_ctrl: got %h expected %h", d, 32'h1B); end
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_mid_irq: got %b expected 0", irq); end
      bus_write(2'd2, 32'h0000_0001);
      b = 8'($urandom);
      send_rx(b, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (40) @(negedge clk);
      bus_read(2'd1, 1'b0, d);
      tests++; if (d !== 32'h105) begin fails++; $display("FAIL post_reset_status: got %h expected %h", d, 32'h105); end
      bus_read(2'd0, 1'b1, d);
      tests++; if (d !== {24'h0, b}) begin fails++; $display("FAIL post_reset_rx: got %h expected %h", d, {24'h0, b}); end
      tests++; if (Tx !== 1'b1) begin fails++; $display("FAIL post_reset_tx_idle: got %b expected 1", Tx); end
   endtask

   initial begin
      test_reset();
      test_tx();
      test_irq();
      test_rx();
      test_overrun();
      test_tx_full();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
